// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
// Widths mirror the core-wide WORD/REGADDR definitions.
package rf_write_arbiter_pkg;

    localparam int DEF_WORD_SIZE    = 32;
    localparam int DEF_REGADDR_SIZE = 5;
    localparam int RF_WR_PORTS      = 2;
    localparam int DEF_NREQ         = 4;
    localparam int DEF_CNT_SIZE     = 16;

    // (base + off) mod n, valid for base < n and off <= n
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_picker.sv
// Round-robin dual-winner picker; second winner must target a
// different register than the first.
module rr_picker
    import rf_write_arbiter_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int REGADDR_SIZE = DEF_REGADDR_SIZE,
    localparam int PTR_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]              valid,
    input  logic [PTR_W-1:0]             ptr,
    input  logic [NREQ*REGADDR_SIZE-1:0] addr,
    output logic [NREQ-1:0]              grant_a,
    output logic [NREQ-1:0]              grant_b,
    output logic                         conflict
);

    logic                    found_a;
    logic                    found_b;
    logic [REGADDR_SIZE-1:0] addr_win;
    logic [PTR_W-1:0]        idx;

    always_comb begin
        grant_a  = '0;
        grant_b  = '0;
        conflict = 1'b0;
        found_a  = 1'b0;
        found_b  = 1'b0;
        addr_win = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'(wrap_idx(int'(ptr), k, NREQ));
            if (valid[idx]) begin
                if (!found_a) begin
                    found_a      = 1'b1;
                    grant_a[idx] = 1'b1;
                    addr_win     = addr[int'(idx)*REGADDR_SIZE +: REGADDR_SIZE];
                end else if (addr[int'(idx)*REGADDR_SIZE +: REGADDR_SIZE] == addr_win) begin
                    // same register as A: deferred this cycle
                    conflict = 1'b1;
                end else if (!found_b) begin
                    found_b      = 1'b1;
                    grant_b[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's two write ports among NREQ writeback
// requesters with round-robin priority and registered RF controls.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int REGADDR_SIZE = DEF_REGADDR_SIZE,
    parameter int CNT_SIZE     = DEF_CNT_SIZE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*REGADDR_SIZE-1:0] req_addr,
    input  logic [NREQ*WORD_SIZE-1:0]    req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         wen_a,
    output logic [REGADDR_SIZE-1:0]      addr_a,
    output logic [WORD_SIZE-1:0]         din_a,
    output logic                         wen_b,
    output logic [REGADDR_SIZE-1:0]      addr_b,
    output logic [WORD_SIZE-1:0]         din_b,
    output logic [CNT_SIZE-1:0]          conflict_cnt
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        ptr_nxt;
    logic [NREQ-1:0]         grant_a;
    logic [NREQ-1:0]         grant_b;
    logic                    conflict;
    logic                    go;
    logic                    any_a;
    logic                    any_b;
    logic [PTR_W-1:0]        idx_a;
    logic [PTR_W-1:0]        idx_b;
    logic [REGADDR_SIZE-1:0] sel_addr_a;
    logic [REGADDR_SIZE-1:0] sel_addr_b;
    logic [WORD_SIZE-1:0]    sel_data_a;
    logic [WORD_SIZE-1:0]    sel_data_b;

    rr_picker #(
        .NREQ        (NREQ),
        .REGADDR_SIZE(REGADDR_SIZE)
    ) u_picker (
        .valid   (req_valid),
        .ptr     (ptr),
        .addr    (req_addr),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .conflict(conflict)
    );

    assign go        = rst & ~hold;
    assign any_a     = |grant_a;
    assign any_b     = |grant_b;
    assign req_ready = go ? (grant_a | grant_b) : '0;

    always_comb begin
        idx_a      = '0;
        idx_b      = '0;
        sel_addr_a = '0;
        sel_addr_b = '0;
        sel_data_a = '0;
        sel_data_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_a[i]) begin
                idx_a      = PTR_W'(i);
                sel_addr_a = req_addr[i*REGADDR_SIZE +: REGADDR_SIZE];
                sel_data_a = req_data[i*WORD_SIZE +: WORD_SIZE];
            end
            if (grant_b[i]) begin
                idx_b      = PTR_W'(i);
                sel_addr_b = req_addr[i*REGADDR_SIZE +: REGADDR_SIZE];
                sel_data_b = req_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
        ptr_nxt = ptr;
        if (any_b)
            ptr_nxt = PTR_W'(wrap_idx(int'(idx_b), 1, NREQ));
        else if (any_a)
            ptr_nxt = PTR_W'(wrap_idx(int'(idx_a), 1, NREQ));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr          <= '0;
            wen_a        <= 1'b0;
            wen_b        <= 1'b0;
            addr_a       <= '0;
            addr_b       <= '0;
            din_a        <= '0;
            din_b        <= '0;
            conflict_cnt <= '0;
        end else begin
            wen_a <= go & any_a;
            wen_b <= go & any_b;
            if (go && any_a) begin
                addr_a <= sel_addr_a;
                din_a  <= sel_data_a;
            end
            if (go && any_b) begin
                addr_b <= sel_addr_b;
                din_b  <= sel_data_b;
            end
            if (go)
                ptr <= ptr_nxt;
            if (go && conflict && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: grants, ports, pointer,
// conflicts, hold/reset and counter saturation.
module tb_rf_write_arbiter;

    localparam int NREQ = 4;
    localparam int WS   = 32;
    localparam int RA   = 5;
    localparam int CS   = 4;

    logic             clk;
    logic             rst;
    logic             hold;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*RA-1:0] req_addr;
    logic [NREQ*WS-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             wen_a;
    logic [RA-1:0]    addr_a;
    logic [WS-1:0]    din_a;
    logic             wen_b;
    logic [RA-1:0]    addr_b;
    logic [WS-1:0]    din_b;
    logic [CS-1:0]    conflict_cnt;

    int total;
    int bad;

    rf_write_arbiter #(
        .NREQ        (NREQ),
        .WORD_SIZE   (WS),
        .REGADDR_SIZE(RA),
        .CNT_SIZE    (CS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wen_a       (wen_a),
        .addr_a      (addr_a),
        .din_a       (din_a),
        .wen_b       (wen_b),
        .addr_b      (addr_b),
        .din_b       (din_b),
        .conflict_cnt(conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [RA-1:0] a,
                           input logic [WS-1:0] d);
        req_addr[i*RA +: RA] = a;
        req_data[i*WS +: WS] = d;
    endtask

    task automatic chk_a(input string tag, input logic [RA-1:0] a,
                         input logic [WS-1:0] d);
        chk({tag, "_wen_a"}, 64'(wen_a), 64'd1);
        chk({tag, "_addr_a"}, 64'(addr_a), 64'(a));
        chk({tag, "_din_a"}, 64'(din_a), 64'(d));
    endtask

    task automatic chk_b(input string tag, input logic [RA-1:0] a,
                         input logic [WS-1:0] d);
        chk({tag, "_wen_b"}, 64'(wen_b), 64'd1);
        chk({tag, "_addr_b"}, 64'(addr_b), 64'(a));
        chk({tag, "_din_b"}, 64'(din_b), 64'(d));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // reset with a pending request: ready must stay low
        #1;
        req_valid = 4'b0001;
        set_req(0, 5'd3, 32'hABCDEF00);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        step();
        step();
        chk("rst_wen_a", 64'(wen_a), 64'd0);
        chk("rst_wen_b", 64'(wen_b), 64'd0);
        chk("rst_addr_a", 64'(addr_a), 64'd0);
        chk("rst_din_a", 64'(din_a), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        chk("rst_ptr", 64'(dut.ptr), 64'd0);

        // single request
        rst = 1'b1;
        #1;
        chk("t1_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        chk_a("t1", 5'd3, 32'hABCDEF00);
        chk("t1_wen_b", 64'(wen_b), 64'd0);
        chk("t1_ptr", 64'(dut.ptr), 64'd1);

        // two distinct requests
        req_valid = 4'b0110;
        set_req(1, 5'd4, 32'h11111111);
        set_req(2, 5'd5, 32'h22222222);
        #1;
        chk("t2_ready", 64'(req_ready), 64'b0110);
        step();
        req_valid = '0;
        chk_a("t2", 5'd4, 32'h11111111);
        chk_b("t2", 5'd5, 32'h22222222);
        chk("t2_ptr", 64'(dut.ptr), 64'd3);

        // single grant wraps ptr to 0; port B idle keeps old values
        req_valid = 4'b1000;
        set_req(3, 5'd9, 32'h99999999);
        #1;
        chk("t2w_ready", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        chk_a("t2w", 5'd9, 32'h99999999);
        chk("t2w_wen_b", 64'(wen_b), 64'd0);
        chk("t2w_addr_b_hold", 64'(addr_b), 64'd5);
        chk("t2w_din_b_hold", 64'(din_b), 64'h22222222);
        chk("t2w_ptr", 64'(dut.ptr), 64'd0);

        // same-address conflict
        req_valid = 4'b1001;
        set_req(0, 5'd7, 32'hA0A0A0A0);
        set_req(3, 5'd7, 32'hD3D3D3D3);
        #1;
        chk("t3_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid = 4'b1000;
        chk_a("t3", 5'd7, 32'hA0A0A0A0);
        chk("t3_wen_b", 64'(wen_b), 64'd0);
        chk("t3_cnt", 64'(conflict_cnt), 64'd1);
        chk("t3_ptr", 64'(dut.ptr), 64'd1);
        #1;
        chk("t3b_ready", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        chk_a("t3b", 5'd7, 32'hD3D3D3D3);
        chk("t3b_wen_b", 64'(wen_b), 64'd0);
        chk("t3b_cnt", 64'(conflict_cnt), 64'd1);
        chk("t3b_ptr", 64'(dut.ptr), 64'd0);

        // fairness: all valid, distinct addresses
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 5'(10 + i), 32'(32'hF0000000 + i));
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t4_ready%0d", c), 64'(req_ready),
                (c % 2 == 0) ? 64'b0011 : 64'b1100);
            step();
            if (c % 2 == 0) begin
                chk_a($sformatf("t4_%0d", c), 5'd10, 32'hF0000000);
                chk_b($sformatf("t4_%0d", c), 5'd11, 32'hF0000001);
                chk($sformatf("t4_ptr%0d", c), 64'(dut.ptr), 64'd2);
            end else begin
                chk_a($sformatf("t4_%0d", c), 5'd12, 32'hF0000002);
                chk_b($sformatf("t4_%0d", c), 5'd13, 32'hF0000003);
                chk($sformatf("t4_ptr%0d", c), 64'(dut.ptr), 64'd0);
            end
        end
        req_valid = '0;

        // hold with a would-be conflict: no grant, no count
        hold      = 1'b1;
        req_valid = 4'b0101;
        set_req(0, 5'd6, 32'h60606060);
        set_req(2, 5'd6, 32'h62626262);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t5_ready%0d", c), 64'(req_ready), 64'd0);
            step();
            chk($sformatf("t5_wen_a%0d", c), 64'(wen_a), 64'd0);
            chk($sformatf("t5_wen_b%0d", c), 64'(wen_b), 64'd0);
            chk($sformatf("t5_ptr%0d", c), 64'(dut.ptr), 64'd0);
            chk($sformatf("t5_cnt%0d", c), 64'(conflict_cnt), 64'd1);
        end
        chk("t5_addr_a_hold", 64'(addr_a), 64'd12);

        // reset in the same cycle a grant would be made
        hold = 1'b0;
        rst  = 1'b0;
        #1;
        chk("t5r_ready", 64'(req_ready), 64'd0);
        step();
        req_valid = '0;
        chk("t5r_wen_a", 64'(wen_a), 64'd0);
        chk("t5r_wen_b", 64'(wen_b), 64'd0);
        chk("t5r_addr_a", 64'(addr_a), 64'd0);
        chk("t5r_din_a", 64'(din_a), 64'd0);
        chk("t5r_addr_b", 64'(addr_b), 64'd0);
        chk("t5r_din_b", 64'(din_b), 64'd0);
        chk("t5r_cnt", 64'(conflict_cnt), 64'd0);
        rst = 1'b1;
        step();
        chk("t5r2_wen_a", 64'(wen_a), 64'd0);
        chk("t5r2_ptr", 64'(dut.ptr), 64'd0);

        // 20 consecutive conflict cycles saturate the 4-bit counter
        req_valid = 4'b0011;
        set_req(0, 5'd8, 32'h80808080);
        set_req(1, 5'd8, 32'h81818181);
        for (int c = 1; c <= 20; c++) begin
            step();
            chk($sformatf("t6_cnt%0d", c), 64'(conflict_cnt),
                64'((c > 15) ? 15 : c));
            chk($sformatf("t6_wen_b%0d", c), 64'(wen_b), 64'd0);
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's two write ports (A, B) among NREQ independent writeback requesters, e.g. ALU, load unit, multiplier and CSR path.
- Grants up to two writes per cycle using round-robin priority and never issues two writes to the same register in one cycle.
- Drives the register file's wen/addr/din pins from registers, so the register file sees clean, glitch-free controls.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WORD_SIZE, 32: data width, matching `WORD.
- REGADDR_SIZE, 5: register address width, matching `REGADDR.
- CNT_SIZE, 16: width of the conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- hold  in  1  freeze; no grants while high.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*REGADDR_SIZE  flattened destination addresses; requester i occupies bits [i*REGADDR_SIZE +: REGADDR_SIZE].
- req_data  in  NREQ*WORD_SIZE  flattened write data, same slicing.
- req_ready  out  NREQ  grant; a write transfers when valid and ready are both high.
- wen_a  out  1  port A write enable to the register file.
- addr_a  out  REGADDR_SIZE  port A address.
- din_a  out  WORD_SIZE  port A data.
- wen_b  out  1  port B write enable.
- addr_b  out  REGADDR_SIZE  port B address.
- din_b  out  WORD_SIZE  port B data.
- conflict_cnt  out  CNT_SIZE  saturating count of cycles in which a same-address conflict deferred a request.

Behaviour:
- Reset (rst=0 at a clk edge):
  - ptr=0, wen_a=wen_b=0, addr_a/addr_b/din_a/din_b=0, conflict_cnt=0.
  - req_ready is held at 0 while rst=0.
  - Reset mid-operation discards any grant decided in that cycle; no write is emitted afterwards.
- Selection (combinational, per cycle):
  - Scan requesters in order ptr, ptr+1, ..., wrapping mod NREQ.
  - First valid requester = winner A.
  - Next valid requester whose address differs from A's = winner B.
  - A valid requester whose address equals A's is skipped. If any such skip occurs this cycle, the cycle is a conflict cycle.
  - req_ready is 1 only for winners A and B, and is 0 for everyone when hold=1 or rst=0.
- Handshake:
  - A transfer occurs on any clk edge where valid&ready.
  - Requesters hold valid, addr and data stable until their transfer; the arbiter does not check this.
  - req_ready may depend combinationally on req_valid/req_addr; there is no combinational path from ready back to valid.
- Output latency: 1 cycle. On the edge after which A transferred:
  - wen_a=1, addr_a/din_a = A's addr/data.
  - Same rule for port B with winner B.
  - With no winner, the enable is 0 and addr/din hold their previous values.
- Port assignment: winner A always uses port A. A single grant is therefore always on port A; wen_b=1 implies wen_a=1 in the same cycle.
- Pointer:
  - After a cycle with at least one grant, ptr <= (index of last winner + 1) mod NREQ. The last winner is B if present, otherwise A.
  - With no grant (idle, hold, or reset), ptr holds.
- conflict_cnt increments on each conflict cycle that is not under hold, and saturates at all-ones.
- Starvation bound: a continuously valid requester is granted within NREQ cycles when hold=0.

Decomposition:
- config.v:
  - Keep `WORD, `REGADDR and their _SIZE macros there.
  - Add `RF_WR_PORTS (2) and the default NREQ there.
- Sub-module rr_picker (NREQ, REGADDR_SIZE):
  - Inputs: valid vector, ptr, flattened addresses.
  - Outputs: one-hot grant_a, one-hot grant_b, conflict flag.
  - Purely combinational.
- rf_write_arbiter contains ptr, the output registers, the counter and the hold/reset gating.

Test Plan:
1. Reset, then single request: rst=0 for 2 cycles, then 1; req0 valid addr=3 data=ABCDEF00. Expect ready[0]=1 in that cycle; next cycle wen_a=1, addr_a=3, din_a=ABCDEF00, wen_b=0; ptr=1.
2. Two distinct requests: req1 addr=4 data=11111111 and req2 addr=5 data=22222222 in the same cycle, ptr=1. Expect both ready; next cycle port A = (4, 11111111), port B = (5, 22222222); ptr=3.
3. Same-address conflict: req0 and req3 both addr=7, ptr=0. Expect only req0 granted; conflict_cnt=1. Next cycle req3 is granted, port A = (7, req3 data), wen_b=0; conflict_cnt stays 1.
4. Fairness: all four requesters continuously valid with distinct addresses for 4 cycles. Expect grant pairs {0,1}, {2,3}, {0,1}, {2,3}, and every requester granted within 2 cycles.
5. Hold and reset mid-operation: req2 valid with hold=1 for 3 cycles. Expect ready=0, wen_a=0, ptr unchanged. Then rst=0 in the same cycle as a grant. Expect no write emitted afterwards and all outputs 0.
6. Counter saturation: with CNT_SIZE=4, 20 consecutive conflict cycles. Expect conflict_cnt=F and no wrap.
